// File: rtl/periph_bus_pkg.sv
// rtl/periph_bus_pkg.sv - shared encodings and defaults for the peripheral bus master
package periph_bus_pkg;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_WR   = 3'd1,
    S_RD   = 3'd2,
    S_ACK  = 3'd3,
    S_ERR  = 3'd4
  } state_t;

  localparam logic [31:0] ADDR_MIN_DEF = 32'h0000_0002;
  localparam logic [31:0] ADDR_MAX_DEF = 32'h0000_0011;
  // Idle value of both bus address outputs; never a mapped peripheral.
  localparam logic [31:0] GUARD_ADDR   = 32'h0000_0000;
  localparam int          CNT_W        = 4;

endpackage

// File: rtl/periph_bus_master.sv
// rtl/periph_bus_master.sv - single-transaction CPU to peripheral bus bridge
// Outputs are registered from the decode of the state being entered, so they line up with that state.
module periph_bus_master
  import periph_bus_pkg::*;
#(
  parameter int unsigned RD_LAT   = 1,
  parameter logic [31:0] ADDR_MIN = ADDR_MIN_DEF,
  parameter logic [31:0] ADDR_MAX = ADDR_MAX_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cpu_req,
  input  logic        cpu_we,
  input  logic [31:0] cpu_addr,
  input  logic [31:0] cpu_wdata,
  output logic [31:0] cpu_rdata,
  output logic        cpu_ack,
  output logic        cpu_err,
  output logic        cpu_busy,
  output logic [31:0] sys_w_addr,
  output logic [31:0] sys_r_addr,
  output logic [31:0] sys_w_line,
  input  logic [31:0] sys_r_line,
  output logic        sys_w,
  output logic        sys_r
);

  localparam logic [CNT_W-1:0] LAT_LOAD = CNT_W'(RD_LAT - 1);

  state_t             r_state;
  state_t             w_state_nxt;
  logic [CNT_W-1:0]   r_cnt;
  logic [31:0]        r_addr;
  logic [31:0]        r_rdata;
  logic               r_ack;
  logic               r_err;
  logic               r_sys_w;
  logic               r_sys_r;
  logic [31:0]        r_w_addr;
  logic [31:0]        r_r_addr;
  logic [31:0]        r_w_line;

  logic               w_in_range;
  logic               w_accept;
  logic               w_rd_last;
  logic [31:0]        w_addr_sel;
  logic               w_ack_nxt;
  logic               w_err_nxt;
  logic               w_sys_w_nxt;
  logic               w_sys_r_nxt;
  logic [31:0]        w_w_addr_nxt;
  logic [31:0]        w_r_addr_nxt;
  logic [31:0]        w_w_line_nxt;

  assign w_in_range = (cpu_addr >= ADDR_MIN) && (cpu_addr <= ADDR_MAX);
  assign w_accept   = (r_state == S_IDLE) && cpu_req;
  assign w_rd_last  = (r_state == S_RD) && (r_cnt == '0);
  // The cpu_* inputs are only looked at on the accept cycle; afterwards the latched address rules.
  assign w_addr_sel = (r_state == S_IDLE) ? cpu_addr : r_addr;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= S_IDLE;
    else      r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      S_IDLE: begin
        if (cpu_req) begin
          if (!w_in_range) w_state_nxt = S_ERR;
          else if (cpu_we) w_state_nxt = S_WR;
          else             w_state_nxt = S_RD;
        end
      end
      S_WR:         w_state_nxt = S_ACK;
      S_RD:         if (r_cnt == '0) w_state_nxt = S_ACK;
      S_ACK, S_ERR: w_state_nxt = S_IDLE;
      default:      w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    w_ack_nxt    = 1'b0;
    w_err_nxt    = 1'b0;
    w_sys_w_nxt  = 1'b0;
    w_sys_r_nxt  = 1'b0;
    w_w_addr_nxt = GUARD_ADDR;
    w_r_addr_nxt = GUARD_ADDR;
    w_w_line_nxt = '0;
    unique case (w_state_nxt)
      S_WR: begin
        w_sys_w_nxt  = 1'b1;
        w_w_addr_nxt = w_addr_sel;
        w_w_line_nxt = cpu_wdata;
      end
      S_RD: begin
        w_sys_r_nxt  = 1'b1;
        w_r_addr_nxt = w_addr_sel;
      end
      S_ACK: w_ack_nxt = 1'b1;
      S_ERR: begin
        w_ack_nxt = 1'b1;
        w_err_nxt = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt    <= '0;
      r_addr   <= '0;
      r_rdata  <= '0;
      r_ack    <= 1'b0;
      r_err    <= 1'b0;
      r_sys_w  <= 1'b0;
      r_sys_r  <= 1'b0;
      r_w_addr <= '0;
      r_r_addr <= '0;
      r_w_line <= '0;
    end else begin
      if (w_accept) begin
        r_addr <= cpu_addr;
        r_cnt  <= LAT_LOAD;
      end else if ((r_state == S_RD) && (r_cnt != '0)) begin
        r_cnt <= r_cnt - 1'b1;
      end
      if (w_rd_last) r_rdata <= sys_r_line;
      r_ack    <= w_ack_nxt;
      r_err    <= w_err_nxt;
      r_sys_w  <= w_sys_w_nxt;
      r_sys_r  <= w_sys_r_nxt;
      r_w_addr <= w_w_addr_nxt;
      r_r_addr <= w_r_addr_nxt;
      r_w_line <= w_w_line_nxt;
    end
  end

  assign cpu_busy   = (r_state != S_IDLE);
  assign cpu_rdata  = r_rdata;
  assign cpu_ack    = r_ack;
  assign cpu_err    = r_err;
  assign sys_w      = r_sys_w;
  assign sys_r      = r_sys_r;
  assign sys_w_addr = r_w_addr;
  assign sys_r_addr = r_r_addr;
  assign sys_w_line = r_w_line;

endmodule

// File: tb/tb_periph_bus_master.sv
// tb/tb_periph_bus_master.sv - self-checking bench for periph_bus_master
module tb_periph_bus_master;

  localparam int RD_LAT = 3;

  logic        clk = 1'b0;
  logic        rst;
  logic        cpu_req;
  logic        cpu_we;
  logic [31:0] cpu_addr;
  logic [31:0] cpu_wdata;
  logic [31:0] cpu_rdata;
  logic        cpu_ack;
  logic        cpu_err;
  logic        cpu_busy;
  logic [31:0] sys_w_addr;
  logic [31:0] sys_r_addr;
  logic [31:0] sys_w_line;
  logic [31:0] sys_r_line;
  logic        sys_w;
  logic        sys_r;

  periph_bus_master #(
    .RD_LAT  (RD_LAT),
    .ADDR_MIN(32'h2),
    .ADDR_MAX(32'h11)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .cpu_req   (cpu_req),
    .cpu_we    (cpu_we),
    .cpu_addr  (cpu_addr),
    .cpu_wdata (cpu_wdata),
    .cpu_rdata (cpu_rdata),
    .cpu_ack   (cpu_ack),
    .cpu_err   (cpu_err),
    .cpu_busy  (cpu_busy),
    .sys_w_addr(sys_w_addr),
    .sys_r_addr(sys_r_addr),
    .sys_w_line(sys_w_line),
    .sys_r_line(sys_r_line),
    .sys_w     (sys_w),
    .sys_r     (sys_r)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rline;
    logic        exp_err;
    logic [31:0] exp_rdata;
  } vec_t;

  typedef struct {
    logic        err;
    int          lat;
    logic [31:0] rdata;
    int          wcnt;
    int          rcnt;
  } exp_t;

  exp_t sb[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   overlap = 0;
  int   err_no_ack = 0;
  bit   mon_en = 1'b0;
  int   m_w = 0;
  int   m_r = 0;
  int   m_ok = 0;
  logic prev_r = 1'b0;

  always @(negedge clk) begin
    if (sys_w && sys_r) overlap++;
    if (cpu_err && !cpu_ack) err_no_ack++;
    if (mon_en) begin
      if (sys_w) m_w++;
      if (sys_r && !prev_r) m_r++;
      if (cpu_ack && !cpu_err) m_ok++;
    end
    prev_r = sys_r;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got no summary expected finish");
    $fatal(1, "watchdog");
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic do_txn(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [31:0] rline, input logic exp_err,
                        input logic [31:0] exp_rdata, input string tag);
    exp_t e;
    exp_t g;
    int   k;
    int   wc;
    int   rc;
    logic bad;
    e.err   = exp_err;
    e.lat   = exp_err ? 1 : (we ? 2 : RD_LAT + 1);
    e.rdata = exp_rdata;
    e.wcnt  = (!exp_err && we) ? 1 : 0;
    e.rcnt  = (!exp_err && !we) ? RD_LAT : 0;
    sb.push_back(e);
    cpu_req    = 1'b1;
    cpu_we     = we;
    cpu_addr   = addr;
    cpu_wdata  = wdata;
    sys_r_line = rline;
    tick();
    cpu_req   = 1'b0;
    cpu_we    = ~we;
    cpu_addr  = ~addr;
    cpu_wdata = ~wdata;
    k = 1; wc = 0; rc = 0; bad = 1'b0;
    while (!cpu_ack && k < 20) begin
      if (sys_w) begin
        wc++;
        if (sys_w_addr !== addr || sys_w_line !== wdata) bad = 1'b1;
      end
      if (sys_r) begin
        rc++;
        if (sys_r_addr !== addr) bad = 1'b1;
      end
      if (!cpu_busy) bad = 1'b1;
      tick();
      k++;
    end
    if (sys_w) wc++;
    if (sys_r) rc++;
    g = sb.pop_front();
    chk($sformatf("%s_ack", tag), 32'(cpu_ack), 1);
    chk($sformatf("%s_lat", tag), k, g.lat);
    chk($sformatf("%s_err", tag), 32'(cpu_err), 32'(g.err));
    chk($sformatf("%s_rdata", tag), cpu_rdata, g.rdata);
    chk($sformatf("%s_wstrobes", tag), wc, g.wcnt);
    chk($sformatf("%s_rstrobes", tag), rc, g.rcnt);
    chk($sformatf("%s_bus", tag), 32'(bad), 0);
    tick();
    chk($sformatf("%s_idle", tag),
        {29'(sys_w_addr | sys_r_addr | sys_w_line), sys_w, sys_r, cpu_busy}, 0);
  endtask

  vec_t        vecs[11];
  logic [31:0] model_rdata;
  logic [7:0]  v_busy, v_w, v_r, v_ack;
  logic [31:0] a_waddr, a_rdata;
  int          acc;

  initial begin
    vecs[0]  = '{1'b1, 32'h0A, 32'hDEADBEEF, 32'h0,        1'b0, 32'h0};
    vecs[1]  = '{1'b0, 32'h02, 32'h0,        32'h12345678, 1'b0, 32'h12345678};
    vecs[2]  = '{1'b1, 32'h01, 32'h13572468, 32'h0,        1'b1, 32'h12345678};
    vecs[3]  = '{1'b0, 32'h12, 32'h0,        32'hAAAA5555, 1'b1, 32'h12345678};
    vecs[4]  = '{1'b0, 32'h11, 32'h0,        32'hCAFEF00D, 1'b0, 32'hCAFEF00D};
    vecs[5]  = '{1'b1, 32'h11, 32'h00000001, 32'h0,        1'b0, 32'hCAFEF00D};
    vecs[6]  = '{1'b1, 32'h02, 32'h00000055, 32'h0,        1'b0, 32'hCAFEF00D};
    vecs[7]  = '{1'b0, 32'h00, 32'h0,        32'h11111111, 1'b1, 32'hCAFEF00D};
    vecs[8]  = '{1'b1, 32'h12, 32'hFFFFFFFF, 32'h0,        1'b1, 32'hCAFEF00D};
    vecs[9]  = '{1'b0, 32'h01, 32'h0,        32'h22222222, 1'b1, 32'hCAFEF00D};
    vecs[10] = '{1'b0, 32'h0A, 32'h0,        32'h0BADC0DE, 1'b0, 32'h0BADC0DE};

    rst = 1'b0; cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0; sys_r_line = '0;
    tick();
    tick();
    chk("reset_ctrl", {27'd0, cpu_ack, cpu_err, cpu_busy, sys_w, sys_r}, 0);
    chk("reset_rdata", cpu_rdata, 0);
    chk("reset_bus", sys_w_addr | sys_r_addr | sys_w_line, 0);
    rst = 1'b1;
    tick();

    for (int i = 0; i < 11; i++)
      do_txn(vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].rline,
             vecs[i].exp_err, vecs[i].exp_rdata, $sformatf("vec%0d", i));

    // Held request: write then read, second accepted in the IDLE cycle after the first ack.
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 32'h5; cpu_wdata = 32'h11112222;
    tick();
    cpu_we = 1'b0; cpu_addr = 32'h6; cpu_wdata = 32'h0; sys_r_line = 32'h77;
    a_waddr = '0; a_rdata = '0;
    for (int i = 1; i <= 8; i++) begin
      if (i > 1) tick();
      v_busy[i-1] = cpu_busy;
      v_w[i-1]    = sys_w;
      v_r[i-1]    = sys_r;
      v_ack[i-1]  = cpu_ack;
      if (i == 1) a_waddr = sys_w_addr ^ sys_w_line;
      if (i == 7) a_rdata = cpu_rdata;
      if (i == 4) cpu_req = 1'b0;
    end
    chk("held_busy", 32'(v_busy), 32'h7B);
    chk("held_sys_w", 32'(v_w), 32'h01);
    chk("held_sys_r", 32'(v_r), 32'h38);
    chk("held_ack", 32'(v_ack), 32'h42);
    chk("held_wbus", a_waddr, 32'h5 ^ 32'h11112222);
    chk("held_rdata", a_rdata, 32'h77);

    // Reset pulsed during the second read cycle.
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h3; sys_r_line = 32'h99;
    tick();
    cpu_req = 1'b0;
    tick();
    chk("mid_rd_strobe", 32'(sys_r), 1);
    #2 rst = 1'b0;
    #1;
    chk("async_rst_ctrl", {27'd0, cpu_ack, cpu_err, cpu_busy, sys_w, sys_r}, 0);
    chk("async_rst_rdata", cpu_rdata, 0);
    chk("async_rst_bus", sys_w_addr | sys_r_addr | sys_w_line, 0);
    tick();
    rst = 1'b1;
    acc = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (cpu_ack || sys_w || sys_r || cpu_busy) acc++;
    end
    chk("post_rst_quiet", acc, 0);
    model_rdata = 32'h0;

    // Random back-to-back traffic.
    mon_en = 1'b1;
    for (int i = 0; i < 30; i++) begin
      logic        r_we;
      logic [31:0] r_addr;
      logic [31:0] r_data;
      logic        r_err;
      r_we   = 1'($urandom_range(0, 1));
      r_addr = 32'($urandom_range(0, 19));
      r_data = $urandom;
      r_err  = (r_addr < 32'h2) || (r_addr > 32'h11);
      if (!r_err && !r_we) model_rdata = r_data;
      do_txn(r_we, r_addr, r_data, r_data, r_err, model_rdata, $sformatf("rnd%0d", i));
    end
    mon_en = 1'b0;
    chk("strobes_vs_ok_acks", m_w + m_r, m_ok);
    chk("rw_overlap", overlap, 0);
    chk("err_without_ack", err_no_ack, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/periph_bus_master.md
PERIPH_BUS_MASTER -- requirements
Module: periph_bus_master

Interface
REQ-001 The block SHALL use one clock and an asynchronous, active-low reset; ports are named clk and rst.
REQ-002 Parameter RD_LAT, default 1, SHALL set the read-strobe cycles before sys_r_line is sampled (legal 1..15).
REQ-003 Parameter ADDR_MIN, default 32'h2, SHALL be the lowest mapped peripheral address.
REQ-004 Parameter ADDR_MAX, default 32'h11, SHALL be the highest mapped peripheral address.
REQ-005 Ports SHALL be:
- clk  in  1  system clock
- rst  in  1  async active-low reset
- cpu_req  in  1  transaction request, sampled in IDLE only
- cpu_we  in  1  1 = write, 0 = read
- cpu_addr  in  32  target peripheral address
- cpu_wdata  in  32  write data
- cpu_rdata  out  32  read data, registered
- cpu_ack  out  1  one-cycle completion pulse
- cpu_err  out  1  one-cycle error flag, coincident with cpu_ack
- cpu_busy  out  1  high whenever state is not IDLE
- sys_w_addr  out  32  peripheral write address
- sys_r_addr  out  32  peripheral read address
- sys_w_line  out  32  peripheral write data
- sys_r_line  in  32  peripheral read data
- sys_w  out  1  write strobe
- sys_r  out  1  read strobe

Function
REQ-006 The FSM SHALL have exactly these states: IDLE, WR, RD, ACK, ERR.
REQ-007 In IDLE with cpu_req=1, the block SHALL latch cpu_we, cpu_addr and cpu_wdata, then go to ERR if the address is outside ADDR_MIN..ADDR_MAX, else to WR if cpu_we=1, else to RD.
REQ-008 In WR, for exactly one cycle, the block SHALL drive sys_w=1, sys_w_addr=latched address and sys_w_line=latched data, then go to ACK.
REQ-009 In RD, the block SHALL drive sys_r=1 and sys_r_addr=latched address for exactly RD_LAT cycles using a 4-bit down-counter.
REQ-010 At the end of the last RD cycle, the block SHALL capture sys_r_line into cpu_rdata, then go to ACK.
REQ-011 ACK SHALL assert cpu_ack=1 with cpu_err=0 for one cycle, then return to IDLE.
REQ-012 ERR SHALL assert cpu_ack=1 and cpu_err=1 for one cycle, issue no bus strobe, leave cpu_rdata unchanged, and return to IDLE.
REQ-013 Latency from the accept cycle N SHALL be: write ack at N+2; read ack at N+RD_LAT+1; error ack at N+1.
REQ-014 cpu_req SHALL be ignored outside IDLE, including the ACK/ERR cycle; a held cpu_req SHALL be accepted in the next IDLE cycle, giving at most one transaction per ack.
REQ-015 Changes to cpu_* inputs after acceptance SHALL NOT affect the transaction in flight.
REQ-016 When not strobing, sys_w, sys_r, sys_w_addr, sys_r_addr and sys_w_line SHALL be 0; address 0 lies in the guard band.
REQ-017 sys_w and sys_r SHALL never be high in the same cycle.
REQ-018 Boundary addresses ADDR_MIN and ADDR_MAX SHALL be accepted; ADDR_MIN-1 and ADDR_MAX+1 SHALL error.
REQ-019 cpu_rdata SHALL hold its value until the next successful read completes.

Reset
REQ-020 Asserting rst low SHALL immediately force state IDLE, all outputs 0, cpu_rdata 0 and the counter 0.
REQ-021 Reset mid-transaction SHALL abort the transaction without any ack, and no strobe SHALL be issued after reset deassertion.

Structure
REQ-022 Package periph_bus_pkg SHALL hold the state encoding, default ADDR_MIN/ADDR_MAX, the guard-band address (0) and the counter width.
REQ-023 The block SHALL be a single module with no sub-module; all outputs are registered except cpu_busy, which is decoded from state.

Verification
REQ-024 Write 0xDEADBEEF to 0x0A -> sys_w=1 for one cycle with sys_w_addr=0x0A and sys_w_line=0xDEADBEEF; cpu_ack at N+2; cpu_err=0.
REQ-025 Read 0x02 with RD_LAT=3 and sys_r_line=0x12345678 -> sys_r high for 3 cycles; cpu_ack at N+4; cpu_rdata=0x12345678.
REQ-026 Requests to 0x01 and 0x12 -> ack with cpu_err=1 at N+1, no strobe, cpu_rdata unchanged; requests to 0x02 and 0x11 -> complete without error.
REQ-027 cpu_req held high across write then read -> second transaction accepted in the cycle after the first ack; cpu_busy low exactly one cycle between them.
REQ-028 rst pulsed low during the second RD cycle (RD_LAT=3) -> all outputs 0 asynchronously, no cpu_ack, IDLE after release.
REQ-029 Random back-to-back traffic -> sys_w&sys_r never 1; strobe count equals non-error ack count.
